// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per
// clock, LSB first, and presents {carry, sum} with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   busy_next, done_next;

    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sbit, cnext, last;

    assign sbit     = a_q[0] ^ b_q[0] ^ c_q;
    assign cnext    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    // Shift the new sum bit in at the MSB; written as shifts so WIDTH=1 works.
    assign acc_next = (acc_q >> 1) | (WIDTH'(sbit) << (WIDTH - 1));
    assign last     = (cnt_q == CNT_W'(WIDTH - 1));

    // State register with registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags decoded from the upcoming state so they register in step with it.
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_next)
            SHIFT:   busy_next = 1'b1;
            DONE:    done_next = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, serial full-adder datapath and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_q   <= a;
                b_q   <= b;
                c_q   <= cin;
                acc_q <= '0;
                cnt_q <= '0;
            end
        end else if (state == SHIFT) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            c_q   <= cnext;
            acc_q <= acc_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                sum   <= acc_next;
                carry <= cnext;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8, carry8, busy8, done8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, carry1, busy1, done1;
    logic [0:0] a1, b1, sum1;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .sum   (sum8),
        .carry (carry8),
        .busy  (busy8),
        .done  (done8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .sum   (sum1),
        .carry (carry1),
        .busy  (busy1),
        .done  (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation: busy for 8 cycles, done 8 edges after acceptance.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [7:0] es, input logic ec, input string tag);
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy8), 32'd1);
            check({tag, "_nodone"}, 32'(done8), 32'd0);
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done8), 32'd1);
        check({tag, "_busy_off"}, 32'(busy8), 32'd0);
        check({tag, "_sum"}, 32'(sum8), 32'(es));
        check({tag, "_carry"}, 32'(carry8), 32'(ec));
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done8), 32'd0);
    endtask

    logic [1:0] fa_tab [8];
    int         done_seen;

    initial begin
        fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_carry8", 32'(carry8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;

        // Basic sums and carry-out cases
        run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "add_0f_01");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");

        // Operand change and start during SHIFT are ignored; next start waits for IDLE
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("chg_busy", 32'(busy8), 32'd1);
            check("chg_nodone", 32'(done8), 32'd0);
        end
        @(negedge clk);
        check("chg_done", 32'(done8), 32'd1);
        check("chg_sum", 32'(sum8), 32'h46);
        check("chg_carry", 32'(carry8), 32'd0);
        @(negedge clk);
        check("chg_idle_busy", 32'(busy8), 32'd0);
        check("chg_idle_done", 32'(done8), 32'd0);
        @(negedge clk);
        check("chg_reaccept", 32'(busy8), 32'd1);
        start8 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("chg2_busy", 32'(busy8), 32'd1);
            check("chg2_hold_sum", 32'(sum8), 32'h46);
        end
        @(negedge clk);
        check("chg2_done", 32'(done8), 32'd1);
        check("chg2_sum", 32'(sum8), 32'hFE);
        check("chg2_carry", 32'(carry8), 32'd1);

        // Reset during the 4th SHIFT cycle aborts the operation
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_carry", 32'(carry8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_sum_hold", 32'(sum8), 32'd0);
        run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_rst");

        // start held high for 30 cycles: done every 10 cycles, result stable between
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("hold_done", 32'(done8), (k % 10 == 9) ? 32'd1 : 32'd0);
            if (k > 9) check("hold_sum", 32'(sum8), 32'h10);
        end
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); start1 = 1'b1;
            @(posedge clk);
            #1 start1 = 1'b0;
            @(negedge clk);
            check("w1_busy", 32'(busy1), 32'd1);
            check("w1_nodone", 32'(done1), 32'd0);
            @(negedge clk);
            check("w1_done", 32'(done1), 32'd1);
            check("w1_result", 32'({carry1, sum1}), 32'(fa_tab[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
